round_sequencer: RTL

//  Sequences one poker hand: PREFLOP->FLOP->TURN->RIVER->TALLY, then CASHOUT or a new hand.

---
 rtl/round_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/round_sequencer.sv
// round_sequencer: poker hand sequencer with card req/ack dealing and chip/pot settlement; `define DUP_REJECT_EN drops repeated cards
module round_sequencer #(
  parameter logic [7:0] START_CHIPS = 8'd100,
  parameter logic [7:0] BET_UNIT    = 8'd5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_advance,
  input  logic       i_bet,
  input  logic       i_cashout_sw,
  input  logic       i_win_in,
  input  logic       i_card_ack,
  input  logic [3:0] i_card_in,
  output logic       o_card_req,
  output logic       o_card_we,
  output logic [2:0] o_card_idx,
  output logic [3:0] o_card_data,
  output logic [2:0] o_round,
  output logic       o_cashed_out,
  output logic       o_busy,
  output logic [7:0] o_chips,
  output logic [7:0] o_pot,
  output logic       o_broke
);
  typedef enum logic [2:0] {PREFLOP = 3'd0, FLOP, TURN, RIVER, TALLY, CASHOUT} state_t;
  state_t     r_state, w_state;
  logic [7:0] r_chips, w_chips, r_pot, w_pot, w_chips_b, w_pot_b, w_settle;
  logic [9:0] w_sum;
  logic [2:0] r_slot, w_slot, r_idx, w_idx;
  logic [1:0] r_left, w_left, w_cnt;
  logic [3:0] r_data, w_data;
  logic       r_req, w_req, r_we, w_we, r_broke, w_broke;
  logic       w_acc, w_dup, w_wr, w_busy, w_play, w_bet_ok, w_adv, w_new;
`ifdef DUP_REJECT_EN
  logic [15:0] r_seen, w_seen;
  assign w_dup = r_seen[i_card_in];
`else
  assign w_dup = 1'b0;
`endif
  assign w_acc    = i_card_ack & r_req;
  assign w_wr     = w_acc & ~w_dup;
  assign w_busy   = r_left != 2'd0;
  assign w_play   = (r_state != TALLY) && (r_state != CASHOUT);
  assign w_bet_ok = i_bet & w_play & ~w_busy & (r_chips >= BET_UNIT);
  assign w_chips_b = w_bet_ok ? r_chips - BET_UNIT : r_chips;
  assign w_pot_b   = w_bet_ok ? r_pot + BET_UNIT : r_pot;
  // bet lands first, so a same-cycle bet on RIVER->TALLY is part of the settled pot
  assign w_sum    = {2'b0, w_chips_b} + {1'b0, w_pot_b, 1'b0};
  assign w_settle = i_win_in ? (|w_sum[9:8] ? 8'hFF : w_sum[7:0]) : w_chips_b;
  assign w_adv    = i_advance & ~w_busy & (r_state != CASHOUT);
  assign w_new    = ((r_state == TALLY) & w_adv & ~i_cashout_sw) | ((r_state == CASHOUT) & ~i_cashout_sw);
  assign w_cnt    = (r_state == PREFLOP) ? 2'd3 : (r_state == RIVER) ? 2'd0 : 2'd1;
  always_comb begin
    w_state = r_state;
    w_chips = w_chips_b;
    w_pot   = w_pot_b;
    w_broke = r_broke;
    w_slot  = w_wr ? r_slot + 3'd1 : r_slot;
    w_left  = w_wr ? r_left - 2'd1 : r_left;
    w_req   = w_busy & ~w_acc;
    w_we    = w_wr;
    w_idx   = w_wr ? r_slot : r_idx;
    w_data  = w_wr ? i_card_in : r_data;
`ifdef DUP_REJECT_EN
    w_seen  = w_wr ? r_seen | (16'd1 << i_card_in) : r_seen;
`endif
    if (w_adv && w_play) begin
      w_state = state_t'(r_state + 3'd1);
      w_left  = w_cnt;
      if (r_state == RIVER) begin
        w_chips = w_settle;
        w_pot   = 8'd0;
        w_broke = w_settle == 8'd0;
      end
    end
    if (w_adv && (r_state == TALLY) && i_cashout_sw)
      w_state = CASHOUT;
    if (w_new) begin
      w_state = PREFLOP;
      w_slot  = 3'd0;
      w_left  = 2'd2;
      w_pot   = 8'd0;
      w_broke = 1'b0;
`ifdef DUP_REJECT_EN
      w_seen  = 16'd0;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PREFLOP;
      r_chips <= START_CHIPS;
      r_pot   <= 8'd0;
      r_broke <= 1'b0;
      r_slot  <= 3'd0;
      r_left  <= 2'd2;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_idx   <= 3'd0;
      r_data  <= 4'd0;
`ifdef DUP_REJECT_EN
      r_seen  <= 16'd0;
`endif
    end else begin
      r_state <= w_state;
      r_chips <= w_chips;
      r_pot   <= w_pot;
      r_broke <= w_broke;
      r_slot  <= w_slot;
      r_left  <= w_left;
      r_req   <= w_req;
      r_we    <= w_we;
      r_idx   <= w_idx;
      r_data  <= w_data;
`ifdef DUP_REJECT_EN
      r_seen  <= w_seen;
`endif
    end
  end
  assign o_card_req   = r_req;
  assign o_card_we    = r_we;
  assign o_card_idx   = r_idx;
  assign o_card_data  = r_data;
  assign o_round      = (r_state == CASHOUT) ? 3'd4 : r_state;
  assign o_cashed_out = r_state == CASHOUT;
  assign o_busy       = w_busy;
  assign o_chips      = r_chips;
  assign o_pot        = r_pot;
  assign o_broke      = r_broke;
endmodule
